// File: rtl/register_one_bit.sv
// register_one_bit: a single-bit storage cell with a load enable.
// Wider registers are built by replicating this cell once per data bit,
// with every copy sharing L, clk and reset.
//
// Ports:
//   clk    rising-edge clock; the only clock in the design
//   reset  synchronous, active-high clear; it takes priority over load
//   D      data bit to store
//   L      load enable, active-high
//   Q      stored bit, driven straight from the flip-flop
module register_one_bit (
  input  logic clk,
  input  logic reset,
  input  logic D,
  input  logic L,
  output logic Q
);

  // Power-up value of 0 keeps a freshly configured register at all zeros
  // before the first clock edge, which matches the wider register.
  logic stored = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      stored <= 1'b0;
    end else if (L) begin
      stored <= D;
    end
  end

  assign Q = stored;

endmodule

// File: tb/tb_register_one_bit.sv
// Directed testbench for register_one_bit. A reference value advances on
// every rising edge using the cell's load/clear rules, and is compared with
// Q on every falling edge. Literal checks at chosen points pin that
// reference, including checks taken between clock edges.
module tb_register_one_bit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic D = 1'b0;
  logic L = 1'b0;
  logic Q;

  int tests = 0;
  int fails = 0;
  bit done = 1'b0;
  logic model_q = 1'b0;

  register_one_bit dut (
    .clk  (clk),
    .reset(reset),
    .D    (D),
    .L    (L),
    .Q    (Q)
  );

  always #5 clk = ~clk;

  // Value the cell must hold after an edge, given the inputs seen at it.
  function automatic logic next_value(logic prev, logic rst, logic ld, logic d);
    return rst ? 1'b0 : (ld ? d : prev);
  endfunction

  always @(posedge clk) model_q <= next_value(model_q, reset, L, D);

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: Q=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) check("model_compare", Q, model_q);
  end

  task automatic edge_step;
    @(posedge clk);
    #1;
  endtask

  // Directed vectors applied from Q=0: {reset, L, D} and the Q after the edge.
  logic [2:0] vec_in [8] = '{3'b011, 3'b000, 3'b100, 3'b001,
                             3'b010, 3'b011, 3'b110, 3'b011};
  logic       vec_q  [8] = '{1'b1, 1'b1, 1'b0, 1'b0,
                             1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, Q=%b expected completion", Q);
    $fatal(1, "timeout");
  end

  initial begin
    // Power-up before any edge.
    #1;
    check("power_up", Q, 1'b0);

    edge_step();
    check("no_reset_hold", Q, 1'b0);

    reset = 1'b1;
    edge_step();
    check("reset_clear", Q, 1'b0);

    // Load 1 then 0.
    reset = 1'b0; L = 1'b1; D = 1'b1;
    edge_step();
    check("load_one", Q, 1'b1);
    D = 1'b0;
    edge_step();
    check("load_zero", Q, 1'b0);

    // Hold with D toggling.
    D = 1'b1;
    edge_step();
    check("hold_setup", Q, 1'b1);
    L = 1'b0;
    for (int i = 0; i < 8; i++) begin
      D = i[0];
      edge_step();
      check("hold_toggle", Q, 1'b1);
    end

    // Reset wins over load.
    reset = 1'b1; L = 1'b0;
    edge_step();
    check("prio_clear", Q, 1'b0);
    reset = 1'b1; L = 1'b1; D = 1'b1;
    edge_step();
    check("prio_reset_wins", Q, 1'b0);
    reset = 1'b0;
    edge_step();
    check("prio_release_load", Q, 1'b1);

    // Reset pulse between edges is not seen.
    L = 1'b0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    check("sync_mid_pulse", Q, 1'b1);
    edge_step();
    check("sync_pulse_missed", Q, 1'b1);
    reset = 1'b1;
    edge_step();
    check("sync_reset_edge", Q, 1'b0);
    reset = 1'b0;

    // Mid-cycle D change only shows after the next edge.
    L = 1'b1; D = 1'b0;
    edge_step();
    check("timing_base", Q, 1'b0);
    @(negedge clk);
    #1 D = 1'b1;
    #1 check("timing_mid_cycle", Q, 1'b0);
    edge_step();
    check("timing_after_edge", Q, 1'b1);

    // Reset clears even with unknown D and L.
    reset = 1'b1; L = 1'bx; D = 1'bx;
    edge_step();
    check("reset_x_inputs", Q, 1'b0);
    L = 1'b0; D = 1'b0;
    edge_step();

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      {reset, L, D} = vec_in[i];
      edge_step();
      check("vector_table", Q, vec_q[i]);
    end

    reset = 1'b0; L = 1'b0;
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
